// File: rtl/evaluate_taper_if.sv
// Bundle between the general evaluator (master) and the taper stage (slave).
interface evaluate_taper_if #(
    parameter int EVAL_WIDTH = 24
);
    logic                         eval_valid;
    logic                         clear_eval;
    logic                         white_to_move;
    logic signed [EVAL_WIDTH-1:0] eval_mg;
    logic signed [EVAL_WIDTH-1:0] eval_eg;
    logic        [31:0]           material_white;
    logic        [31:0]           material_black;
    logic                         insufficient_material;
    logic        [8:0]            phase;
    logic signed [EVAL_WIDTH-1:0] score;
    logic                         score_valid;

    modport master (
        output eval_valid, clear_eval, white_to_move, eval_mg, eval_eg,
               material_white, material_black, insufficient_material,
        input  phase, score, score_valid
    );

    modport slave (
        input  eval_valid, clear_eval, white_to_move, eval_mg, eval_eg,
               material_white, material_black, insufficient_material,
        output phase, score, score_valid
    );
endinterface

// File: rtl/evaluate_taper.sv
// Tapered mg/eg blend to a side-to-move score with draw forcing and saturation.
// Optional side-to-move tempo bonus enabled by defining EVAL_TAPER_TEMPO_EN.
//
// state | meaning
// IDLE  | waiting for a rising edge of eval_valid
// RUN   | captured inputs flowing through the five-stage pipeline
// DONE  | score/phase/score_valid held until cleared
module evaluate_taper #(
    parameter int EVAL_WIDTH    = 24,
    parameter int MATERIAL_FULL = 8000,
    parameter int MATERIAL_END  = 1000,
    parameter int TEMPO         = 10
) (
    input logic             clk,
    input logic             reset,
    evaluate_taper_if.slave bus
);
    localparam int W  = EVAL_WIDTH;
    localparam int WP = EVAL_WIDTH + 10;
    localparam int WS = EVAL_WIDTH + 11;

    localparam logic [32:0] FULL_33 = 33'(MATERIAL_FULL);
    localparam logic [32:0] END_33  = 33'(MATERIAL_END);
    localparam logic [63:0] RECIP   = (64'd256 << 16) / 64'(MATERIAL_FULL - MATERIAL_END);

    localparam logic signed [WS-1:0] SAT_MAX = WS'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [WS-1:0] SAT_MIN = -SAT_MAX;

`ifdef EVAL_TAPER_TEMPO_EN
    localparam logic signed [WS-1:0] TEMPO_ADD = WS'(TEMPO);
`else
    // Tempo disabled: parameter kept for interface compatibility only.
    localparam logic signed [WS-1:0] TEMPO_ADD = WS'(TEMPO * 0);
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;
    logic   eval_valid_q;
    logic   capture, finish, kill;
    logic [4:0] stage_v_q;

    logic signed [W-1:0] mg_c, eg_c;
    logic [31:0]         mw_c, mb_c;
    logic                wtm_c, ins_c;

    logic [32:0]          total_q;
    logic [8:0]           phase_q;
    logic signed [WP-1:0] pm_q, pe_q;
    logic signed [WP-1:0] t_q;

    logic [63:0]          phase_prod;
    logic [8:0]           phase_d;
    logic signed [WP-1:0] mg_ext, eg_ext, ph_ext, inv_ext;
    logic signed [WS-1:0] s_d, s_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            eval_valid_q <= 1'b0;
            stage_v_q    <= '0;
        end else begin
            state_q      <= state_d;
            eval_valid_q <= bus.eval_valid;
            stage_v_q    <= kill ? 5'd0 : {stage_v_q[3:0], capture};
        end
    end

    // A falling eval_valid after acceptance behaves exactly like clear_eval.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        finish  = 1'b0;
        kill    = bus.clear_eval |
                  ((state_q != IDLE) & eval_valid_q & ~bus.eval_valid);
        case (state_q)
            IDLE: begin
                if (bus.eval_valid && !eval_valid_q) begin
                    capture = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stage_v_q[4]) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d = IDLE;
            capture = 1'b0;
            finish  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mg_c  <= '0;
            eg_c  <= '0;
            mw_c  <= '0;
            mb_c  <= '0;
            wtm_c <= 1'b0;
            ins_c <= 1'b0;
        end else if (capture) begin
            mg_c  <= bus.eval_mg;
            eg_c  <= bus.eval_eg;
            mw_c  <= bus.material_white;
            mb_c  <= bus.material_black;
            wtm_c <= bus.white_to_move;
            ins_c <= bus.insufficient_material;
        end
    end

    always_comb begin
        phase_prod = 64'(total_q - END_33) * RECIP;
        if (total_q >= FULL_33)
            phase_d = 9'd256;
        else if (total_q <= END_33)
            phase_d = 9'd0;
        else
            phase_d = 9'(phase_prod >> 16);
    end

    always_comb begin
        mg_ext  = {{10{mg_c[W-1]}}, mg_c};
        eg_ext  = {{10{eg_c[W-1]}}, eg_c};
        ph_ext  = {{(W + 1){1'b0}}, phase_q};
        inv_ext = {{(W + 1){1'b0}}, 9'd256 - phase_q};
    end

    // Stages run every cycle off the held capture registers; stage_v_q tracks validity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_q <= '0;
            phase_q <= '0;
            pm_q    <= '0;
            pe_q    <= '0;
            t_q     <= '0;
        end else begin
            total_q <= {1'b0, mw_c} + {1'b0, mb_c};
            phase_q <= phase_d;
            pm_q    <= mg_ext * ph_ext;
            pe_q    <= eg_ext * inv_ext;
            t_q     <= (pm_q + pe_q) >>> 8;
        end
    end

    always_comb begin
        s_d = wtm_c ? WS'(t_q) : -WS'(t_q);
        if (ins_c)
            s_d = '0;
        else
            s_d = s_d + TEMPO_ADD;
        if (s_d > SAT_MAX)
            s_sat = SAT_MAX;
        else if (s_d < SAT_MIN)
            s_sat = SAT_MIN;
        else
            s_sat = s_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.score       <= '0;
            bus.phase       <= '0;
            bus.score_valid <= 1'b0;
        end else if (kill) begin
            bus.score_valid <= 1'b0;
        end else if (finish) begin
            bus.score       <= s_sat[W-1:0];
            bus.phase       <= phase_q;
            bus.score_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_evaluate_taper.sv
// Self-checking bench for evaluate_taper against an arithmetic reference model.
module tb_evaluate_taper;
    localparam int  W     = 24;
    localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W - 1));
`ifdef EVAL_TAPER_TEMPO_EN
    localparam longint TEMPO_B = 10;
`else
    localparam longint TEMPO_B = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    evaluate_taper_if #(.EVAL_WIDTH(W)) bus ();

    evaluate_taper #(
        .EVAL_WIDTH(W), .MATERIAL_FULL(8000), .MATERIAL_END(1000), .TEMPO(10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint floor_div256(input longint x);
        longint r;
        r = ((x % 256) + 256) % 256;
        return (x - r) / 256;
    endfunction

    function automatic void model(input longint mg, input longint eg, input longint mw,
                                  input longint mb, input bit wtm, input bit ins,
                                  output longint ph, output longint sc);
        longint total, recip, t, s;
        total = mw + mb;
        recip = (256 * 65536) / (8000 - 1000);
        if (total >= 8000)      ph = 256;
        else if (total <= 1000) ph = 0;
        else                    ph = ((total - 1000) * recip) / 65536;
        t = floor_div256(mg * ph + eg * (256 - ph));
        s = wtm ? t : -t;
        s = ins ? 0 : s + TEMPO_B;
        if (s > MAXV)  s = MAXV;
        if (s < -MAXV) s = -MAXV;
        sc = s;
    endfunction

    task automatic do_eval(input longint mg, input longint eg, input longint mw,
                           input longint mb, input bit wtm, input bit ins);
        longint ph, sc;
        int lat;
        model(mg, eg, mw, mb, wtm, ins, ph, sc);
        @(negedge clk);
        bus.eval_mg               = W'(mg);
        bus.eval_eg               = W'(eg);
        bus.material_white        = 32'(mw);
        bus.material_black        = 32'(mb);
        bus.white_to_move         = wtm;
        bus.insufficient_material = ins;
        bus.eval_valid            = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.score_valid && lat < 20);
        check("latency", lat - 1, 5);
        check("phase", bus.phase, ph);
        check("score", bus.score, sc);
    endtask

    task automatic clear_all();
        @(negedge clk);
        bus.clear_eval = 1'b1;
        bus.eval_valid = 1'b0;
        @(negedge clk);
        bus.clear_eval = 1'b0;
        check("cleared", bus.score_valid, 0);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.score_valid) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        longint mg, eg;
        reset                     = 1'b1;
        bus.eval_valid            = 1'b0;
        bus.clear_eval            = 1'b0;
        bus.white_to_move         = 1'b0;
        bus.eval_mg               = '0;
        bus.eval_eg               = '0;
        bus.material_white        = '0;
        bus.material_black        = '0;
        bus.insufficient_material = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_score", bus.score, 0);
        check("rst_phase", bus.phase, 0);
        check("rst_valid", bus.score_valid, 0);
        reset = 1'b0;

        do_eval(100, -50, 4000, 4000, 1, 0);
        check("spec_mg_white", bus.score, 100 + TEMPO_B);
        repeat (3) @(posedge clk);
        #1;
        check("hold_valid", bus.score_valid, 1);
        clear_all();
        do_eval(100, -50, 4000, 4000, 0, 0);
        clear_all();
        do_eval(100, -50, 400, 400, 1, 0);
        check("spec_eg_phase", bus.phase, 0);
        clear_all();
        do_eval(100, -50, 2250, 2250, 1, 0);
        check("spec_mid_phase", bus.phase, 127);
        clear_all();
        do_eval(-1, -1, 2250, 2250, 1, 0);
        clear_all();
        do_eval(500, 500, 4000, 4000, 1, 1);
        check("spec_draw", bus.score, 0);
        clear_all();
        do_eval(500, 500, 4000, 4000, 1, 0);
        clear_all();
        do_eval(MAXV, MAXV, 3000, 3000, 0, 0);
        clear_all();
        do_eval(MINV, MINV, 100, 0, 0, 0);
        check("spec_sat", bus.score, MAXV);

        // eval_valid held high: a lone clear must not restart the pipeline
        @(negedge clk);
        bus.clear_eval = 1'b1;
        @(negedge clk);
        bus.clear_eval = 1'b0;
        watch_quiet("no_second_result", 10);

        // falling eval_valid acts as a clear
        clear_all();
        do_eval(300, 200, 1000, 1500, 1, 0);
        @(negedge clk);
        bus.eval_valid = 1'b0;
        @(negedge clk);
        check("fall_clears", bus.score_valid, 0);

        // clear two cycles after capture
        @(negedge clk);
        bus.eval_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.clear_eval = 1'b1;
        bus.eval_valid = 1'b0;
        @(negedge clk);
        bus.clear_eval = 1'b0;
        watch_quiet("clear_mid_run", 10);

        // clear beats a same-cycle rise
        @(negedge clk);
        bus.clear_eval = 1'b1;
        bus.eval_valid = 1'b1;
        @(negedge clk);
        bus.clear_eval = 1'b0;
        watch_quiet("clear_priority", 10);
        clear_all();

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       mg = MAXV - longint'($urandom_range(0, 3));
                1:       mg = MINV + longint'($urandom_range(0, 3));
                default: mg = longint'($urandom_range(0, 2000000)) - 1000000;
            endcase
            eg = longint'($urandom_range(0, 16000000)) - 8000000;
            do_eval(mg, eg, longint'($urandom_range(0, 6000)), longint'($urandom_range(0, 6000)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            clear_all();
        end

        // reset in the middle of a run with a nonzero previous result on the outputs
        do_eval(700, 900, 3000, 2000, 1, 0);
        clear_all();
        @(negedge clk);
        bus.eval_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        bus.eval_valid = 1'b0;
        #1;
        check("midrst_score", bus.score, 0);
        check("midrst_phase", bus.phase, 0);
        check("midrst_valid", bus.score_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        watch_quiet("after_reset", 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
